// File: rtl/mfe_pkg.sv
// mfe_pkg: constants, state encoding and address helper shared by the
// MFE median-filter stages (window fetch, median core, writeback).
//   IMG_W, IMG_H : image geometry in pixels (powers of 2)
//   AW, DW       : pixel-address and pixel-data widths
//   mfe_state_e  : window-fetch FSM encoding, also exported for debug
//   pix_addr     : row-major pixel address, row*IMG_W+col
package mfe_pkg;

  localparam int IMG_W = 128;
  localparam int IMG_H = 128;
  localparam int AW    = 14;
  localparam int DW    = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SHIFT = 3'd2,
    EMIT  = 3'd3,
    DONE  = 3'd4
  } mfe_state_e;

  // IMG_W is a power of 2, so row*IMG_W+col is a plain concatenation.
  function automatic logic [AW-1:0] pix_addr(input logic [$clog2(IMG_H)-1:0] row,
                                             input logic [$clog2(IMG_W)-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/mfe_window_fetch.sv
// mfe_window_fetch: input front end of the MFE median filter. Walks the image
// in raster order and presents one zero-padded 3x3 neighbourhood per output
// pixel to the median core.
//
// Ports
//   clk, reset    single clock; asynchronous active-high reset
//   ready         start request, sampled only in IDLE
//   fetch_active  high from start until the last window is accepted (incl. DONE)
//   fetch_done    one-cycle pulse in DONE
//   iaddr         image read address; idata returns its data one cycle later
//   idata         image data for the previous cycle's iaddr
//   win_valid     window and address valid (EMIT)
//   win_ready     median core accepts the window
//   win_pix       p0..p8 row-major, p0 (top-left) in bits [DW-1:0], p4 centre
//   win_addr      output-pixel address of the window centre
//   fsm_state     current FSM state, for observation only
//
// Handshake: a window transfers on a posedge where win_valid && win_ready.
// While win_valid is high and win_ready low, win_valid, win_pix and win_addr
// hold their values; win_ready is ignored whenever win_valid is low.
//
// Per row r the columns k=0..IMG_W are fetched one at a time: three read
// slots (image rows r-1, r, r+1), then a shift of the L/M/R column registers.
// Column IMG_W is the right pad; rows -1/IMG_H and columns -1/IMG_W are never
// addressed, the slot just reads as zero and iaddr keeps its last value.
module mfe_window_fetch
  import mfe_pkg::*;
#(
  parameter int IMG_W = mfe_pkg::IMG_W,
  parameter int IMG_H = mfe_pkg::IMG_H,
  parameter int AW    = mfe_pkg::AW,
  parameter int DW    = mfe_pkg::DW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ready,
  output logic            fetch_active,
  output logic            fetch_done,
  output logic [AW-1:0]   iaddr,
  input  logic [DW-1:0]   idata,
  output logic            win_valid,
  input  logic            win_ready,
  output logic [9*DW-1:0] win_pix,
  output logic [AW-1:0]   win_addr,
  output mfe_state_e      fsm_state
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  mfe_state_e state, state_next;

  logic [RW-1:0] row;          // current output row r
  logic [CW:0]   col;          // column being fetched, k = 0..IMG_W
  logic [1:0]    slot;         // read slot j within FETCH
  logic          slot_ok;      // slot j addresses a real pixel this cycle
  logic          slot_ok_q;    // idata this cycle belongs to a real pixel
  logic [RW-1:0] slot_row;
  logic [AW-1:0] iaddr_q;
  logic [DW-1:0] fetched;
  logic [CW-1:0] centre_col;

  logic [DW-1:0] col_l [3];    // column k-2 after the shift (left)
  logic [DW-1:0] col_m [3];    // column k-1 (centre)
  logic [DW-1:0] col_r [3];    // column k   (right)
  logic [DW-1:0] stage [2];    // slots 0 and 1 of the column being fetched

  // ---------------------------------------------------------------- read slot
  always_comb begin
    slot_row = row;
    slot_ok  = 1'b0;
    case (slot)
      2'd0: begin
        slot_row = row - 1'b1;
        slot_ok  = (row != '0);
      end
      2'd1: begin
        slot_row = row;
        slot_ok  = 1'b1;
      end
      2'd2: begin
        slot_row = row + 1'b1;
        slot_ok  = (row != ROW_LAST);
      end
      default: begin
        slot_row = row;
        slot_ok  = 1'b0;
      end
    endcase
    slot_ok = slot_ok && !col[CW] && (state == FETCH);
  end

  // iaddr is presented in the same cycle as the slot; outside a real read it
  // repeats last cycle's value so the image port sees no spurious address.
  assign iaddr   = slot_ok ? AW'({slot_row, col[CW-1:0]}) : iaddr_q;
  assign fetched = slot_ok_q ? idata : '0;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (ready) state_next = FETCH;
      FETCH: if (slot == 2'd2) state_next = SHIFT;
      SHIFT: state_next = (col == '0) ? FETCH : EMIT;
      EMIT: begin
        if (win_ready) begin
          if (col[CW] && (row == ROW_LAST)) state_next = DONE;
          else                               state_next = FETCH;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row       <= '0;
      col       <= '0;
      slot      <= '0;
      slot_ok_q <= 1'b0;
      iaddr_q   <= '0;
      stage     <= '{default: '0};
      col_l     <= '{default: '0};
      col_m     <= '{default: '0};
      col_r     <= '{default: '0};
    end else begin
      iaddr_q   <= iaddr;
      slot_ok_q <= slot_ok;
      case (state)
        IDLE: begin
          if (ready) begin
            row   <= '0;
            col   <= '0;
            slot  <= '0;
            col_l <= '{default: '0};
            col_m <= '{default: '0};
            col_r <= '{default: '0};
          end
        end
        FETCH: begin
          slot <= (slot == 2'd2) ? 2'd0 : slot + 2'd1;
          // data for slot j-1 arrives while slot j is being addressed
          if (slot == 2'd1) stage[0] <= fetched;
          if (slot == 2'd2) stage[1] <= fetched;
        end
        SHIFT: begin
          col_l    <= col_m;
          col_m    <= col_r;
          col_r[0] <= stage[0];
          col_r[1] <= stage[1];
          col_r[2] <= fetched;
          // column 0 only primes the registers; no window is centred yet
          if (col == '0) col <= {{CW{1'b0}}, 1'b1};
        end
        EMIT: begin
          if (win_ready) begin
            if (!col[CW]) begin
              col <= col + 1'b1;
            end else if (row != ROW_LAST) begin
              row   <= row + 1'b1;
              col   <= '0;
              col_l <= '{default: '0};
              col_m <= '{default: '0};
              col_r <= '{default: '0};
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- outputs
  // Low CW bits of k-1; at the right pad k=IMG_W this wraps to IMG_W-1.
  assign centre_col   = col[CW-1:0] - 1'b1;

  assign fetch_active = (state != IDLE);
  assign fetch_done   = (state == DONE);
  assign win_valid    = (state == EMIT);
  assign win_addr     = win_valid ? AW'({row, centre_col}) : '0;
  assign fsm_state    = state;

  always_comb begin
    win_pix = '0;
    if (win_valid) begin
      for (int j = 0; j < 3; j++) begin
        win_pix[j*3*DW +: 3*DW] = {col_r[j], col_m[j], col_l[j]};
      end
    end
  end

endmodule

// File: tb/tb_mfe_window_fetch.sv
// tb_mfe_window_fetch: scoreboard bench for mfe_window_fetch on a 16x8 image.
// Expected windows are built from the bench's own image copy with a direct
// 3x3 zero-padded neighbourhood model and queued when a frame is started;
// a negedge monitor pops and compares every accepted window.
module tb_mfe_window_fetch;
  import mfe_pkg::*;

  localparam int W         = 16;
  localparam int H         = 8;
  localparam int TAW       = 7;
  localparam int TDW       = 8;
  localparam int NPIX      = W * H;
  localparam int EW        = TAW + 9 * TDW;
  localparam int FRAME_CYC = H * (4 + 5 * W) + 1;

  // ---------------------------------------------------------------- clock/reset, DUT
  logic             clk = 1'b0;
  logic             reset;
  logic             ready;
  logic             win_ready = 1'b0;
  logic             fetch_active, fetch_done, win_valid;
  logic [TAW-1:0]   iaddr, win_addr;
  logic [TDW-1:0]   idata;
  logic [9*TDW-1:0] win_pix;
  mfe_state_e       fsm_state;

  always #5 clk = ~clk;

  mfe_window_fetch #(.IMG_W(W), .IMG_H(H), .AW(TAW), .DW(TDW)) dut (
    .clk          (clk),
    .reset        (reset),
    .ready        (ready),
    .fetch_active (fetch_active),
    .fetch_done   (fetch_done),
    .iaddr        (iaddr),
    .idata        (idata),
    .win_valid    (win_valid),
    .win_ready    (win_ready),
    .win_pix      (win_pix),
    .win_addr     (win_addr),
    .fsm_state    (fsm_state)
  );

  // image memory: one-cycle read latency
  logic [TDW-1:0] mem [NPIX];
  always @(posedge clk) idata <= mem[iaddr];

  // ---------------------------------------------------------------- bookkeeping
  int checks = 0;
  int errors = 0;

  logic [EW-1:0]    exp_q[$];
  logic [9*TDW-1:0] seen [NPIX];
  int               rd_cnt [NPIX];
  int               act_cnt = 0;
  int               done_cnt = 0;
  int               double_done = 0;
  int               off_fetch = 0;
  bit               mon_en = 1'b0;
  bit               count_en = 1'b0;
  bit               stall_mode = 1'b0;
  bit               first_pending = 1'b0;
  logic [TAW-1:0]   first_acc_addr = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // independent neighbourhood model
  function automatic logic [9*TDW-1:0] model_win(input int y, input int x);
    logic [9*TDW-1:0] p;
    int yy, xx;
    p = '0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        yy = y + dy;
        xx = x + dx;
        if (yy >= 0 && yy < H && xx >= 0 && xx < W)
          p[((dy + 1) * 3 + (dx + 1)) * TDW +: TDW] = mem[yy * W + xx];
      end
    end
    return p;
  endfunction

  // ---------------------------------------------------------------- driver tasks
  task automatic push_frame();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        exp_q.push_back({TAW'(y * W + x), model_win(y, x)});
  endtask

  task automatic start_frame();
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit got;
    got = 1'b0;
    for (int n = 0; n < budget && !got; n++) begin
      @(negedge clk);
      got = fetch_done;
    end
    check("done_within_budget", 128'(got), 128'(1));
  endtask

  task automatic fill_ramp();
    for (int a = 0; a < NPIX; a++) mem[a] = TDW'(a);
  endtask

  // win_ready: tied high, or a coin toss per cycle while stalling
  always @(posedge clk) begin
    #1;
    if (stall_mode) win_ready = ($urandom_range(0, 1) == 1);
    else            win_ready = 1'b1;
  end

  // ---------------------------------------------------------------- monitor / scoreboard
  always @(negedge clk) begin : monitor
    logic [EW-1:0]    e;
    logic [EW-1:0]    held;
    bit               stalled;
    bit               done_prev;
    logic [TAW-1:0]   prev_iaddr;
    if (reset) begin
      stalled   = 1'b0;
      done_prev = 1'b0;
    end else begin
      if (stalled)
        check("stall_hold", 128'({win_valid, win_addr, win_pix}), 128'({1'b1, held}));
      if (win_valid && win_ready) begin
        if (exp_q.size() == 0) begin
          check("window_without_expectation", 128'(win_addr), 128'(1) << 100);
        end else begin
          e = exp_q.pop_front();
          check("window", 128'({win_addr, win_pix}), 128'(e));
        end
        seen[win_addr] = win_pix;
        if (first_pending) begin
          first_acc_addr = win_addr;
          first_pending  = 1'b0;
        end
        stalled = 1'b0;
      end else begin
        stalled = win_valid;
        held    = {win_addr, win_pix};
      end
      if (fetch_active) act_cnt++;
      if (fetch_done) done_cnt++;
      if (fetch_done && done_prev) double_done++;
      done_prev = fetch_done;
      if (mon_en && (iaddr !== prev_iaddr)) begin
        if (fsm_state != FETCH) off_fetch++;
        if (count_en) rd_cnt[iaddr]++;
      end
    end
    prev_iaddr = iaddr;
  end

  // ---------------------------------------------------------------- stimulus
  initial begin : main
    int  a0, d0, bad, exp_rd;
    bit  hit;
    reset = 1'b1;
    ready = 1'b0;
    fill_ramp();
    repeat (3) @(negedge clk);
    check("reset_outputs", 128'({fetch_active, fetch_done, win_valid, iaddr, win_addr, win_pix}), '0);
    check("reset_state", 128'(fsm_state), 128'(IDLE));
    reset = 1'b0;
    @(negedge clk);
    check("idle_outputs", 128'({fetch_active, fetch_done, win_valid, iaddr, win_addr, win_pix}), '0);

    // 1: ramp, no back-pressure
    mon_en = 1'b1;
    push_frame();
    a0 = act_cnt;
    start_frame();
    wait_done(2 * FRAME_CYC);
    @(negedge clk);
    check("ramp_active_cycles", 128'(act_cnt - a0), 128'(FRAME_CYC));
    check("ramp_queue_drained", 128'(exp_q.size()), 0);
    check("ramp_win_0_0", 128'(seen[0]), 128'(72'h111000010000000000));
    check("ramp_win_2_5", 128'(seen[37]), 128'(72'h363534262524161514));
    check("ramp_win_7_15", 128'(seen[127]), 128'(72'h000000007F7E006F6E));

    // 2: all-FF image, corner and top-edge windows
    for (int a = 0; a < NPIX; a++) mem[a] = 8'hFF;
    push_frame();
    a0 = act_cnt;
    start_frame();
    wait_done(2 * FRAME_CYC);
    @(negedge clk);
    check("ff_active_cycles", 128'(act_cnt - a0), 128'(FRAME_CYC));
    check("ff_queue_drained", 128'(exp_q.size()), 0);
    check("ff_corner_7_15", 128'(seen[127]), 128'(72'h00000000FFFF00FFFF));
    check("ff_edge_0_8", 128'(seen[8]), 128'(72'hFFFFFFFFFFFF000000));

    // 3: ramp again under random back-pressure
    fill_ramp();
    stall_mode = 1'b1;
    push_frame();
    start_frame();
    wait_done(4 * FRAME_CYC);
    stall_mode = 1'b0;
    @(negedge clk);
    check("stall_queue_drained", 128'(exp_q.size()), 0);

    // 4: address monitor over a full frame
    for (int a = 0; a < NPIX; a++) mem[a] = TDW'(a * 37 + 11);
    for (int a = 0; a < NPIX; a++) rd_cnt[a] = 0;
    count_en = 1'b1;
    push_frame();
    a0 = act_cnt;
    start_frame();
    wait_done(2 * FRAME_CYC);
    @(negedge clk);
    count_en = 1'b0;
    mon_en   = 1'b0;
    check("hash_active_cycles", 128'(act_cnt - a0), 128'(FRAME_CYC));
    check("hash_queue_drained", 128'(exp_q.size()), 0);
    check("iaddr_change_outside_fetch", 128'(off_fetch), 0);
    bad = 0;
    for (int a = 0; a < NPIX; a++) begin
      exp_rd = ((a / W) == 0 || (a / W) == H - 1) ? 2 : 3;
      if (rd_cnt[a] != exp_rd) begin
        if (bad == 0) $display("first bad read count at addr %0d: %0d vs %0d", a, rd_cnt[a], exp_rd);
        bad++;
      end
    end
    check("read_count_bad_addrs", 128'(bad), 0);

    // 5: reset in the middle of a frame, then restart
    fill_ramp();
    push_frame();
    start_frame();
    hit = 1'b0;
    for (int n = 0; n < 2 * FRAME_CYC && !hit; n++) begin
      @(negedge clk);
      hit = win_valid && (win_addr == TAW'(50));
    end
    check("reached_window_50", 128'(hit), 128'(1));
    #2 reset = 1'b1;
    #1 check("outputs_at_reset", 128'({fetch_active, fetch_done, win_valid, iaddr, win_addr, win_pix}), '0);
    exp_q.delete();
    @(negedge clk);
    check("outputs_next_cycle", 128'({fetch_active, fetch_done, win_valid, iaddr, win_addr, win_pix}), '0);
    check("state_after_reset", 128'(fsm_state), 128'(IDLE));
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_after_reset", 128'({fetch_active, win_valid}), '0);
    first_pending = 1'b1;
    push_frame();
    start_frame();
    wait_done(2 * FRAME_CYC);
    @(negedge clk);
    check("first_addr_after_restart", 128'(first_acc_addr), 0);
    check("restart_queue_drained", 128'(exp_q.size()), 0);

    // 6: ready held high -> back-to-back frames, one per IDLE entry
    push_frame();
    push_frame();
    d0 = done_cnt;
    @(negedge clk);
    ready = 1'b1;
    wait_done(2 * FRAME_CYC);
    @(negedge clk);
    check("idle_between_frames", 128'(fetch_active), 0);
    @(negedge clk);
    check("restart_with_ready_high", 128'(fetch_active), 128'(1));
    ready = 1'b0;
    wait_done(2 * FRAME_CYC);
    repeat (4) @(negedge clk);
    check("no_extra_frame", 128'(fetch_active), 0);
    check("done_pulses_two_frames", 128'(done_cnt - d0), 128'(2));
    check("held_ready_queue_drained", 128'(exp_q.size()), 0);
    check("done_pulse_single_cycle", 128'(double_done), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
